// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low {G,F,E,D,C,B,A} digit patterns,
// the blank pattern, and the reader FSM state type.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } reader_state_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational segment-pattern to hex-nibble lookup; unknown patterns flag err.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  seg_t       pattern,
  output logic [3:0] value,
  output logic       err
);

  // Map each legal digit pattern to its nibble; everything else is an error with value 0.
  always_comb begin
    value = 4'h0;
    err   = 1'b0;
    case (pattern)
      SEG_0:   value = 4'h0;
      SEG_1:   value = 4'h1;
      SEG_2:   value = 4'h2;
      SEG_3:   value = 4'h3;
      SEG_4:   value = 4'h4;
      SEG_5:   value = 4'h5;
      SEG_6:   value = 4'h6;
      SEG_7:   value = 4'h7;
      SEG_8:   value = 4'h8;
      SEG_9:   value = 4'h9;
      SEG_A:   value = 4'hA;
      SEG_B:   value = 4'hB;
      SEG_C:   value = 4'hC;
      SEG_D:   value = 4'hD;
      SEG_E:   value = 4'hE;
      SEG_F:   value = 4'hF;
      default: err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Reads an asynchronous active-low seven-segment bus, debounces it, decodes
// each newly settled digit and offers it as a valid/ready transaction.
//
//   state      | meaning
//   -----------+-------------------------------------------
//   ST_IDLE    | no pending transaction, valid=0
//   ST_PRESENT | value/err held for the consumer, valid=1
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       ready,
  output logic [3:0] value,
  output logic       err,
  output logic       valid,
  output logic       overrun
);

  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_BEFORE = 8'(STABLE_CYCLES - 1);

  seg_t          sync1, sync2, prev, last;
  logic [7:0]    cnt;
  logic          accept, produce, handshake, load, overrun_set;
  logic [3:0]    dec_value;
  logic          dec_err;
  reader_state_t state, state_nxt;

  sevenseg_decode u_decode (
    .pattern (sync2),
    .value   (dec_value),
    .err     (dec_err)
  );

  // Two-flop synchronizer for the asynchronous segment lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= SEG_BLANK;
      sync2 <= SEG_BLANK;
    end else begin
      sync1 <= {G, F, E, D, C, B, A};
      sync2 <= sync1;
    end
  end

  // Stability counter: restarts on any change of the synchronized pattern, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= SEG_BLANK;
      cnt  <= 8'd0;
    end else begin
      prev <= sync2;
      if (sync2 != prev)
        cnt <= 8'd0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
    end
  end

  // Acceptance fires on the edge where the counter reaches the limit, so the
  // FSM can load in that same edge; blank and repeated patterns give no transaction.
  assign accept    = (sync2 == prev) && (cnt == CNT_BEFORE);
  assign produce   = accept && (sync2 != last) && (sync2 != SEG_BLANK);
  assign handshake = (state == ST_PRESENT) && ready;

  // Last accepted pattern tracks every acceptance, including blanks and dropped ones.
  always_ff @(posedge clk) begin
    if (rst)
      last <= SEG_BLANK;
    else if (accept)
      last <= sync2;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // FSM next-state: a handshake coinciding with a new digit keeps the FSM presenting.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (produce) state_nxt = ST_PRESENT;
      ST_PRESENT: if (handshake && !produce) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: valid, data-load strobe and overrun strobe.
  always_comb begin
    valid       = 1'b0;
    load        = 1'b0;
    overrun_set = 1'b0;
    case (state)
      ST_IDLE:    load = produce;
      ST_PRESENT: begin
        valid       = 1'b1;
        load        = produce && ready;
        overrun_set = produce && !ready;
      end
      default:    valid = 1'b0;
    endcase
  end

  // Transaction data and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      value   <= 4'h0;
      err     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        value <= dec_value;
        err   <= dec_err;
      end
      if (overrun_set)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_reader.sv
// Self-checking bench for sevenseg_reader: directed vector table, hand-written
// overrun/reset sequences and randomized traffic against a history-based model.
module tb_sevenseg_reader;

  localparam int S  = 4;
  localparam int HL = S + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] pat;
  logic       ready;
  logic [3:0] value;
  logic       err, valid, overrun;

  always #5 clk = ~clk;

  sevenseg_reader #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (pat[0]),
    .B       (pat[1]),
    .C       (pat[2]),
    .D       (pat[3]),
    .E       (pat[4]),
    .F       (pat[5]),
    .G       (pat[6]),
    .ready   (ready),
    .value   (value),
    .err     (err),
    .valid   (valid),
    .overrun (overrun)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] legal [16];

  // Reference model state: raw input samples per edge (index 0 = newest).
  logic [6:0] hist [HL];
  logic [6:0] m_last;
  bit         m_pend;
  logic [3:0] m_value;
  bit         m_err;
  bit         m_ovr;

  typedef struct {
    logic [6:0] p;
    int         hold;
    int         exp_txn;
    int         exp_lat;
    logic [3:0] exp_val;
    bit         exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void decode_ref(input logic [6:0] p, output logic [3:0] v, output bit e);
    v = 4'h0;
    e = 1'b1;
    for (int i = 0; i < 16; i++)
      if (legal[i] == p) begin
        v = 4'(i);
        e = 1'b0;
      end
  endfunction

  // A pattern settles at this edge when it was sampled S+1 times in a row two
  // edges ago (synchronizer delay) and the sample before that run was different.
  task automatic model_edge();
    bit         hs, run_ok, acc, prod;
    logic [6:0] x;
    logic [3:0] v;
    bit         e;
    if (rst) begin
      for (int i = 0; i < HL; i++) hist[i] = 7'h7F;
      m_last  = 7'h7F;
      m_pend  = 1'b0;
      m_value = 4'h0;
      m_err   = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      hs = m_pend && ready;
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pat;
      x = hist[2];
      run_ok = 1'b1;
      for (int i = 3; i <= 2 + S; i++) if (hist[i] != x) run_ok = 1'b0;
      acc  = run_ok && (hist[3+S] != x);
      prod = acc && (x != m_last) && (x != 7'h7F);
      if (acc) m_last = x;
      if (prod) begin
        if (!m_pend || hs) begin
          decode_ref(x, v, e);
          m_value = v;
          m_err   = e;
          m_pend  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (hs) begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic [6:0] p, input logic r, input logic rs);
    pat   = p;
    ready = r;
    rst   = rs;
    @(posedge clk);
    model_edge();
    #1;
    check("model_valid",   int'(valid),   int'(m_pend));
    check("model_value",   int'(value),   int'(m_value));
    check("model_err",     int'(err),     int'(m_err));
    check("model_overrun", int'(overrun), int'(m_ovr));
  endtask

  // Holds one pattern for n edges, reporting valid cycles, first valid edge and presented data.
  task automatic hold(input logic [6:0] p, input logic r, input int n,
                      output int txns, output int first, output logic [3:0] v, output bit e);
    txns  = 0;
    first = -1;
    v     = 4'h0;
    e     = 1'b0;
    for (int i = 1; i <= n; i++) begin
      cycle(p, r, 1'b0);
      if (valid) begin
        txns++;
        if (first < 0) first = i;
        v = value;
        e = err;
      end
    end
  endtask

  initial begin
    int         txns, first;
    logic [3:0] v;
    bit         e;

    legal = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0] = '{7'h24, 12, 1, S + 3, 4'h2, 1'b0};
    vecs[1] = '{7'h00,  2, 0, -1,    4'h0, 1'b0};
    vecs[2] = '{7'h24, 12, 0, -1,    4'h0, 1'b0};
    vecs[3] = '{7'h7F, 12, 0, -1,    4'h0, 1'b0};
    vecs[4] = '{7'h0E, 12, 1, S + 3, 4'hF, 1'b0};
    vecs[5] = '{7'h55, 12, 1, S + 3, 4'h0, 1'b1};
    vecs[6] = '{7'h08, 12, 1, S + 3, 4'hA, 1'b0};

    for (int i = 0; i < 3; i++) cycle(7'h7F, 1'b1, 1'b1);
    check("reset_valid",   int'(valid),   0);
    check("reset_value",   int'(value),   0);
    check("reset_err",     int'(err),     0);
    check("reset_overrun", int'(overrun), 0);

    for (int k = 0; k < 7; k++) begin
      hold(vecs[k].p, 1'b1, vecs[k].hold, txns, first, v, e);
      check($sformatf("vec%0d_txns", k), txns, vecs[k].exp_txn);
      if (vecs[k].exp_txn > 0) begin
        check($sformatf("vec%0d_latency", k), first, vecs[k].exp_lat);
        check($sformatf("vec%0d_value", k), int'(v), int'(vecs[k].exp_val));
        check($sformatf("vec%0d_err", k), int'(e), int'(vecs[k].exp_err));
      end
    end

    // Overrun: consumer stalled while a second digit settles.
    hold(7'h79, 1'b0, 12, txns, first, v, e);
    check("ovr_first_latency", first, S + 3);
    check("ovr_first_value", int'(value), 1);
    check("ovr_before", int'(overrun), 0);
    hold(7'h30, 1'b0, 12, txns, first, v, e);
    check("ovr_hold_valid", int'(valid), 1);
    check("ovr_hold_value", int'(value), 1);
    check("ovr_flag", int'(overrun), 1);
    cycle(7'h30, 1'b1, 1'b0);
    check("ovr_release_valid", int'(valid), 0);
    hold(7'h30, 1'b1, 10, txns, first, v, e);
    check("ovr_no_dropped_txn", txns, 0);
    check("ovr_sticky", int'(overrun), 1);

    // Reset while presenting, digit steady on the bus.
    hold(7'h12, 1'b0, 12, txns, first, v, e);
    check("rst_pre_valid", int'(valid), 1);
    check("rst_pre_value", int'(value), 5);
    cycle(7'h12, 1'b0, 1'b1);
    check("rst_drop_valid", int'(valid), 0);
    check("rst_clear_overrun", int'(overrun), 0);
    hold(7'h12, 1'b0, S + 6, txns, first, v, e);
    check("rst_re_latency", first, S + 3);
    check("rst_re_value", int'(v), 5);
    cycle(7'h12, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 300; seg++) begin
      logic [6:0] p;
      int         n;
      case ($urandom_range(0, 3))
        0, 1:    p = legal[$urandom_range(0, 15)];
        2:       p = 7'h7F;
        default: p = 7'($urandom);
      endcase
      n = $urandom_range(1, 9);
      for (int c = 0; c < n; c++)
        cycle(p, ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
